// File: rtl/checkpoint_monitor_pkg.sv
// Shared types and constants for the checkpoint word monitor.
// Holds the FSM state encoding, the well-known firmware codes and a width helper.
package checkpoint_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [15:0] CP_START = 16'hA040;
  localparam logic [15:0] CP_PASS  = 16'hA090;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/checkpoint_monitor_checkbit_sync_filter.sv
// Two-flop synchronizer for the raw pad word followed by a stability filter.
// settle_pulse fires once per settle event, so a held value is reported only once.
module checkbit_sync_filter #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] value,
  output logic             settle_pulse
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [WIDTH-1:0] cand;
  logic [3:0]       cnt;
  logic             reported;

  // A new synchronized value restarts the count and re-arms the settle report.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_1   <= '0;
      sync_2   <= '0;
      cand     <= '0;
      cnt      <= '0;
      reported <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      if (sync_2 != cand) begin
        cand     <= sync_2;
        cnt      <= 4'd1;
        reported <= 1'b0;
      end else begin
        if (cnt != STABLE) cnt <= cnt + 4'd1;
        if (settle_pulse) reported <= 1'b1;
      end
    end
  end

  assign settle_pulse = (cnt == STABLE) && !reported;
  assign value        = cand;

endmodule

// File: rtl/checkpoint_monitor.sv
// Watches the settled checkpoint word and checks that the expected codes arrive in order.
// Reports pass, fail (strict mismatch or timeout) and progress through the sequence.
module checkpoint_monitor
  import checkpoint_monitor_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NUM_CODES      = 4,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int STRICT         = 0
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       enable,
  input  logic [NUM_CODES*WIDTH-1:0] exp_codes,
  input  logic [WIDTH-1:0]           checkbits,
  output logic                       busy,
  output logic                       start_seen,
  output logic                       advance,
  output logic [3:0]                 stage,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [WIDTH-1:0]           bad_code
);

  localparam int             TW_RAW = clog2(TIMEOUT_CYCLES + 1);
  localparam int             TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0]  TLAST  = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LAST   = 4'(NUM_CODES - 1);

  state_t           state;
  logic             enable_q;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] cand;
  logic             settle_pulse;
  logic [3:0]       stage_prev;
  logic [WIDTH-1:0] cur_code;
  logic [WIDTH-1:0] prev_code;
  logic             hit;
  logic             strict_miss;
  logic             timed_out;

  checkbit_sync_filter #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clock       (clock),
    .resetb      (resetb),
    .din         (checkbits),
    .value       (cand),
    .settle_pulse(settle_pulse)
  );

  assign stage_prev  = (stage == 4'd0) ? 4'd0 : stage - 4'd1;
  assign cur_code    = exp_codes[int'(stage)*WIDTH +: WIDTH];
  assign prev_code   = exp_codes[int'(stage_prev)*WIDTH +: WIDTH];
  assign hit         = settle_pulse && (cand == cur_code);
  assign strict_miss = (STRICT != 0) && (stage != 4'd0) && settle_pulse &&
                       (cand != prev_code) && (cand != cur_code);
  assign timed_out   = (TIMEOUT_CYCLES != 0) && (tcnt == TLAST);
  assign busy        = (state == WAIT);

  // Dropping enable aborts from any state; PASS and FAIL otherwise hold their flags.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      enable_q   <= 1'b0;
      stage      <= 4'd0;
      tcnt       <= '0;
      start_seen <= 1'b0;
      advance    <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      bad_code   <= '0;
    end else begin
      enable_q   <= enable;
      start_seen <= 1'b0;
      advance    <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        stage    <= 4'd0;
        tcnt     <= '0;
        pass     <= 1'b0;
        fail     <= 1'b0;
        timeout  <= 1'b0;
        bad_code <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!enable_q) begin
              state <= WAIT;
              stage <= 4'd0;
              tcnt  <= '0;
            end
          end
          WAIT: begin
            if (tcnt != TLAST) tcnt <= tcnt + 1'b1;
            if (hit) begin
              advance <= 1'b1;
              if (stage == 4'd0) start_seen <= 1'b1;
              if (stage == LAST) begin
                pass  <= 1'b1;
                state <= PASS;
              end else begin
                stage <= stage + 4'd1;
              end
            end
            // A final match in the same cycle as the timeout still counts as a pass.
            if (!(hit && stage == LAST)) begin
              if (strict_miss) begin
                bad_code <= cand;
                fail     <= 1'b1;
                state    <= FAIL;
              end else if (timed_out) begin
                fail    <= 1'b1;
                timeout <= 1'b1;
                state   <= FAIL;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
